mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port, word-wide, no-byte-enable memory between the instruction-fetch and load/store sides of the RV32 core. It handles sub-word stores by read-modify-write. While an access is pending it stalls the datapath's PC and register write. It sits between the datapath's PC/Addr/Data ports and the memory IP.

## Interface
Parameters:
- MEM_LAT, default 1: memory read latency in cycles; legal values are 1 to 3.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high with if_addr stable until if_valid.
- if_addr  in  32  fetch byte address; bits [1:0] are ignored.
- if_rdata  out  32  fetched word; registered and held between completions.
- if_valid  out  1  one-cycle fetch completion pulse.
- d_req  in  1  load/store request; held high with its fields stable until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data, right-aligned.
- d_byte_n  in  2  access size: BYTE_N_B = 2'b00, BYTE_N_H = 2'b01, BYTE_N_W = 2'b10.
- d_rdata  out  32  raw aligned word for the datapath's extend/shift logic; registered and held.
- d_valid  out  1  one-cycle data completion pulse.
- d_err  out  1  misaligned access flag; valid only when d_valid is high.
- stall  out  1  combinational: (if_req & ~if_valid) | (d_req & ~d_valid).
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  30  word address, equal to the selected byte address [31:2].
- mem_wdata  out  32  memory write word.
- mem_rdata  in  32  memory read data, valid MEM_LAT cycles after a read enable.

## Operation
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WR, RMW_RD, RMW_WAIT, RMW_WR.
- IDLE arbitration:
  - d_req takes priority over if_req.
  - When both are high, data is served first and fetch is accepted on the next IDLE cycle.
- Data request decode:
  - Misaligned means: half access with d_addr[0] = 1, or word access with d_addr[1:0] ≠ 0. It completes in ERR with d_valid = d_err = 1. No memory access is made and d_rdata is unchanged.
  - Load, or fetch → RD_ISSUE.
  - Word store → WR.
  - Byte or half store → RMW_RD.
- RD_ISSUE / RMW_RD:
  - mem_en = 1, mem_we = 0.
  - A 2-bit wait counter loads MEM_LAT−1; then the FSM moves to RD_WAIT / RMW_WAIT.
  - When MEM_LAT = 1, the wait state is its single completion cycle.
- RD_WAIT: when the counter reaches 0:
  - capture mem_rdata into if_rdata or d_rdata;
  - pulse the owner's valid in the same cycle, with rdata equal to mem_rdata;
  - return to IDLE.
- WR: mem_en = mem_we = 1, mem_wdata = d_wdata; d_valid pulses; return to IDLE.
- RMW_WAIT: when the counter reaches 0, register the merged word, then go to RMW_WR.
  - Byte store: lane d_addr[1:0] is replaced by d_wdata[7:0].
  - Half store: half d_addr[1] is replaced by d_wdata[15:0].
- RMW_WR: write the merged word, pulse d_valid, return to IDLE.
- Transaction ownership:
  - An accepted transaction always completes, even if req drops; dropping req early is a protocol violation.
  - At least one IDLE cycle separates transactions.
  - req still high in the cycle after valid is treated as a new request.
- Reset:
  - Every output register is 0: if_rdata, d_rdata, valids, d_err, mem_en, mem_we, mem_wdata.
  - The state goes to IDLE.
  - mem_en and mem_we are gated by ~rst, so a write in flight during the reset cycle is suppressed.
  - Any pending transaction is dropped.

## Timing
Request first seen in IDLE in cycle T:
- Fetch or load: mem_en in T+1; valid in T+1+MEM_LAT.
- Word store: write and d_valid in T+1.
- Sub-word store: read in T+1, merge in T+1+MEM_LAT, write and d_valid in T+2+MEM_LAT.
- Misaligned access: d_valid and d_err in T+1.
- Memory control signals (mem_en, mem_we, mem_addr, mem_wdata) are decoded only from registered state and the latched request; none depends combinationally on req.
- stall goes low in the valid cycle, so the datapath's PC advances at the end of that cycle.

## Structure
- The shared header (Lab4.vh) holds BYTE_N_B, BYTE_N_H and BYTE_N_W, plus localparam encodings for the FSM states (including ERR).
- A combinational sub-module, store_merge, takes old word, wdata, addr[1:0] and byte_n and outputs the merged word. It is unit-testable on its own.

## Test plan
- MEM_LAT=1, fetch only, if_addr=0x10, mem[4]=0x00500093 → mem_en in T+1; if_valid and if_rdata=0x00500093 in T+2; stall high in T and T+1.
- Simultaneous if_req (0x20) and d_req load (0x104) → data served first, d_valid at T+2; fetch accepted at T+3, if_valid at T+5.
- Byte store, mem[0x41]=0x11223344, d_addr=0x106, d_wdata=0xAB:
  - MEM_LAT=1: the word written at T+3 is 0x11AB3344.
  - Repeat with MEM_LAT=3: the write moves to T+5.
- Half store at d_addr=0x103 → d_valid and d_err in T+1; mem_we stays 0 throughout.
- Assert rst during RMW_WR → mem_we=0 in that cycle; memory unchanged; the next cycle is IDLE with all outputs 0.
- Word store 0xDEADBEEF at 0x200, then a load from 0x200 → d_rdata=0xDEADBEEF; mem_addr=0x80 for both.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// access-size encodings, FSM state encoding and the alignment rule.
package mem_port_arbiter_pkg;

  localparam logic [1:0] BYTE_N_B = 2'b00;
  localparam logic [1:0] BYTE_N_H = 2'b01;
  localparam logic [1:0] BYTE_N_W = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_WR,
    S_RMW_RD,
    S_RMW_WAIT,
    S_RMW_WR,
    S_ERR
  } state_e;

  // Any size other than byte or half is handled as a full word.
  function automatic logic is_word(input logic [1:0] byte_n);
    return (byte_n != BYTE_N_B) && (byte_n != BYTE_N_H);
  endfunction

  function automatic logic is_misaligned(input logic [1:0] byte_n, input logic [1:0] lane);
    return ((byte_n == BYTE_N_H) && lane[0]) || (is_word(byte_n) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/mem_port_arbiter_store_merge.sv
// Combinational byte/half merge of store data into a word read from memory,
// used by the read-modify-write path of the arbiter.
module store_merge
  import mem_port_arbiter_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  byte_n,
  output logic [31:0] merged
);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    merged = old_word;
    case (byte_n)
      BYTE_N_B: merged[{addr, 3'b000} +: 8]        = wdata[7:0];
      BYTE_N_H: merged[{addr[1], 4'b0000} +: 16]   = wdata[15:0];
      default:  merged                             = wdata;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one word-wide single-port memory between instruction fetch and
// load/store, with read-modify-write for sub-word stores and a datapath stall.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_byte_n,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_err,
  output logic        stall,
  output logic        mem_en,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] WAIT_INIT = 2'(MEM_LAT - 1);

  state_e      state_q, state_d;
  logic        own_d_q;
  logic [31:0] addr_q, wdata_q, merged_q, merge_out;
  logic [31:0] if_rdata_q, d_rdata_q;
  logic [1:0]  byte_n_q, cnt_q;
  logic        rd_done;

  store_merge u_store_merge (
    .old_word (mem_rdata),
    .wdata    (wdata_q),
    .addr     (addr_q[1:0]),
    .byte_n   (byte_n_q),
    .merged   (merge_out)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (d_req) begin
          if (is_misaligned(d_byte_n, d_addr[1:0])) state_d = S_ERR;
          else if (!d_we)                           state_d = S_RD_ISSUE;
          else if (is_word(d_byte_n))               state_d = S_WR;
          else                                      state_d = S_RMW_RD;
        end else if (if_req) begin
          state_d = S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT:  if (cnt_q == 2'd0) state_d = S_IDLE;
      S_RMW_RD:   state_d = S_RMW_WAIT;
      S_RMW_WAIT: if (cnt_q == 2'd0) state_d = S_RMW_WR;
      default:    state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      own_d_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      byte_n_q   <= BYTE_N_B;
      cnt_q      <= 2'd0;
      merged_q   <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE) begin
        if (d_req) begin
          own_d_q  <= 1'b1;
          addr_q   <= d_addr;
          wdata_q  <= d_wdata;
          byte_n_q <= d_byte_n;
        end else if (if_req) begin
          own_d_q <= 1'b0;
          addr_q  <= if_addr;
        end
      end
      if (state_q == S_RD_ISSUE || state_q == S_RMW_RD) cnt_q <= WAIT_INIT;
      else if (cnt_q != 2'd0)                           cnt_q <= cnt_q - 2'd1;
      if (rd_done && own_d_q)  d_rdata_q  <= mem_rdata;
      if (rd_done && !own_d_q) if_rdata_q <= mem_rdata;
      if (state_q == S_RMW_WAIT && cnt_q == 2'd0) merged_q <= merge_out;
    end
  end

  // Completion is decoded from registered state; rdata bypasses the holding
  // register so the data is already correct in the valid cycle.
  assign rd_done  = (state_q == S_RD_WAIT) && (cnt_q == 2'd0) && !rst;
  assign if_valid = rd_done && !own_d_q;
  assign d_valid  = !rst && ((rd_done && own_d_q) || state_q == S_WR ||
                             state_q == S_RMW_WR || state_q == S_ERR);
  assign d_err    = !rst && (state_q == S_ERR);
  assign if_rdata = if_valid ? mem_rdata : if_rdata_q;
  assign d_rdata  = (rd_done && own_d_q) ? mem_rdata : d_rdata_q;
  assign stall    = (if_req && !if_valid) || (d_req && !d_valid);

  assign mem_en    = !rst && (state_q == S_RD_ISSUE || state_q == S_RMW_RD ||
                              state_q == S_WR || state_q == S_RMW_WR);
  assign mem_we    = !rst && (state_q == S_WR || state_q == S_RMW_WR);
  assign mem_addr  = addr_q[31:2];
  assign mem_wdata = (state_q == S_WR)     ? wdata_q  :
                     (state_q == S_RMW_WR) ? merged_q : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at MEM_LAT=1 (instance 0) and
// MEM_LAT=3 (instance 1), each with its own latency-accurate memory model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        mem_init;
  logic        if_req [2], if_valid [2];
  logic [31:0] if_addr [2], if_rdata [2];
  logic        d_req [2], d_we [2], d_valid [2], d_err [2], stall [2];
  logic [31:0] d_addr [2], d_wdata [2], d_rdata [2];
  logic [1:0]  d_byte_n [2];
  logic        mem_en [2], mem_we [2];
  logic [29:0] mem_addr [2];
  logic [31:0] mem_wdata [2], mem_rdata [2];

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_lat
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] mem [256];
    logic [31:0] pipe [3];

    mem_port_arbiter #(.MEM_LAT(LAT)) u_dut (
      .clk(clk), .rst(rst[g]),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_rdata(if_rdata[g]), .if_valid(if_valid[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_byte_n(d_byte_n[g]), .d_rdata(d_rdata[g]), .d_valid(d_valid[g]), .d_err(d_err[g]),
      .stall(stall[g]), .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
    );

    always @(posedge clk) begin
      if (mem_init) begin
        for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
        mem[8'h04] <= 32'h0050_0093;
        mem[8'h41] <= 32'h1122_3344;
      end else if (mem_en[g] && mem_we[g]) begin
        mem[mem_addr[g][7:0]] <= mem_wdata[g];
      end
      pipe[0] <= mem[mem_addr[g][7:0]];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign mem_rdata[g] = pipe[LAT-1];
  end

  typedef struct {
    bit          is_d;
    int          due;
    bit          chk_data;
    logic [31:0] data;
    logic        err;
    logic        we;
    logic [31:0] wword;
    logic [31:0] maddr;
  } exp_t;
  exp_t sb [$];

  function automatic int lat(input int p);
    return (p == 0) ? 1 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input int p, input string tag);
    check({tag, "_if_rdata"}, if_rdata[p], 32'h0);
    check({tag, "_d_rdata"}, d_rdata[p], 32'h0);
    check({tag, "_mem_wdata"}, mem_wdata[p], 32'h0);
    check({tag, "_flags"}, {27'h0, if_valid[p], d_valid[p], d_err[p], mem_en[p], mem_we[p]}, 32'h0);
  endtask

  // delay: extra cycles the fetch spends waiting behind a data transaction.
  task automatic issue_fetch(input int p, input logic [31:0] addr, input logic [31:0] data,
                             input int delay);
    exp_t e;
    if_req[p]  = 1'b1;
    if_addr[p] = addr;
    e = '{is_d: 1'b0, due: cyc + 1 + lat(p) + delay, chk_data: 1'b1, data: data,
          err: 1'b0, we: 1'b0, wword: 32'h0, maddr: {2'b00, addr[31:2]}};
    sb.push_back(e);
  endtask

  task automatic issue_data(input int p, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [1:0] bn,
                            input logic [31:0] exp_rdata, input bit chk_rdata,
                            input logic [31:0] exp_wword);
    exp_t e;
    bit   mis;
    int   due;
    mis = ((bn == BYTE_N_H) && addr[0]) || ((bn == BYTE_N_W) && (addr[1:0] != 2'b00));
    if (mis)                   due = cyc + 1;
    else if (!we)              due = cyc + 1 + lat(p);
    else if (bn == BYTE_N_W)   due = cyc + 1;
    else                       due = cyc + 2 + lat(p);
    d_req[p] = 1'b1; d_we[p] = we; d_addr[p] = addr; d_wdata[p] = wdata; d_byte_n[p] = bn;
    e = '{is_d: 1'b1, due: due, chk_data: chk_rdata, data: exp_rdata, err: mis,
          we: we && !mis, wword: exp_wword, maddr: {2'b00, addr[31:2]}};
    sb.push_back(e);
  endtask

  // Waits for the port's valid pulse, pops the oldest expectation and checks it.
  task automatic wait_done(input int p, input bit is_d, input int budget, input string tag);
    bit   seen;
    exp_t e;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = is_d ? d_valid[p] : if_valid[p];
    end
    check_bit({tag, "_valid_seen"}, seen, 1'b1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (seen) begin
        check({tag, "_cycle"}, 32'(cyc), 32'(e.due));
        check_bit({tag, "_stall"}, stall[p], is_d ? if_req[p] : d_req[p]);
        if (is_d) begin
          if (e.chk_data) check({tag, "_d_rdata"}, d_rdata[p], e.data);
          check_bit({tag, "_d_err"}, d_err[p], e.err);
          check_bit({tag, "_mem_we"}, mem_we[p], e.we);
          if (e.we) begin
            check({tag, "_mem_wdata"}, mem_wdata[p], e.wword);
            check({tag, "_mem_addr"}, 32'(mem_addr[p]), e.maddr);
          end
        end else begin
          check({tag, "_if_rdata"}, if_rdata[p], e.data);
        end
      end
    end
    next_cycle();
    if (is_d) d_req[p] = 1'b0;
    else      if_req[p] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_init = 1'b1;
    for (int p = 0; p < 2; p++) begin
      rst[p] = 1'b1; if_req[p] = 1'b0; if_addr[p] = '0; d_req[p] = 1'b0; d_we[p] = 1'b0;
      d_addr[p] = '0; d_wdata[p] = '0; d_byte_n[p] = BYTE_N_W;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0; mem_init = 1'b0;
    @(negedge clk);
    check_zero(0, "reset0");
    check_zero(1, "reset1");
    check_bit("reset_stall", stall[0], 1'b0);

    // Fetch only.
    next_cycle();
    issue_fetch(0, 32'h10, 32'h0050_0093, 0);
    @(negedge clk);
    check_bit("fetch_stall_T", stall[0], 1'b1);
    check_bit("fetch_mem_en_T", mem_en[0], 1'b0);
    @(negedge clk);
    check_bit("fetch_mem_en_T1", mem_en[0], 1'b1);
    check_bit("fetch_stall_T1", stall[0], 1'b1);
    check("fetch_mem_addr", 32'(mem_addr[0]), 32'h4);
    wait_done(0, 1'b0, 8, "fetch");

    // Simultaneous requests: data first, fetch after one IDLE cycle.
    next_cycle();
    issue_data(0, 1'b0, 32'h104, 32'h0, BYTE_N_W, 32'h1122_3344, 1'b1, 32'h0);
    issue_fetch(0, 32'h20, 32'hC0DE_0008, 3);
    wait_done(0, 1'b1, 8, "contend_load");
    wait_done(0, 1'b0, 8, "contend_fetch");

    // Byte store by read-modify-write at both latencies.
    next_cycle();
    issue_data(0, 1'b1, 32'h106, 32'hAB, BYTE_N_B, 32'h0, 1'b0, 32'h11AB_3344);
    wait_done(0, 1'b1, 10, "byte_st_lat1");
    check("byte_st_lat1_mem", g_lat[0].mem[8'h41], 32'h11AB_3344);
    next_cycle();
    issue_data(1, 1'b1, 32'h106, 32'hAB, BYTE_N_B, 32'h0, 1'b0, 32'h11AB_3344);
    wait_done(1, 1'b1, 12, "byte_st_lat3");
    check("byte_st_lat3_mem", g_lat[1].mem[8'h41], 32'h11AB_3344);

    // Half store to lane 2 merges into the upper half.
    next_cycle();
    issue_data(0, 1'b1, 32'h106, 32'h5566, BYTE_N_H, 32'h0, 1'b0, 32'h5566_3344);
    wait_done(0, 1'b1, 10, "half_st");

    // Misaligned half store and word load: immediate error, no memory write.
    next_cycle();
    issue_data(0, 1'b1, 32'h103, 32'h1234, BYTE_N_H, 32'h1122_3344, 1'b1, 32'h0);
    @(negedge clk);
    check_bit("mis_half_mem_we_T", mem_we[0], 1'b0);
    wait_done(0, 1'b1, 4, "mis_half");
    next_cycle();
    issue_data(0, 1'b0, 32'h201, 32'h0, BYTE_N_W, 32'h1122_3344, 1'b1, 32'h0);
    wait_done(0, 1'b1, 4, "mis_word");

    // Word store then load back from the same address.
    next_cycle();
    issue_data(0, 1'b1, 32'h200, 32'hDEAD_BEEF, BYTE_N_W, 32'h0, 1'b0, 32'hDEAD_BEEF);
    wait_done(0, 1'b1, 4, "word_st");
    next_cycle();
    issue_data(0, 1'b0, 32'h200, 32'h0, BYTE_N_W, 32'hDEAD_BEEF, 1'b1, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check_bit("word_ld_mem_en", mem_en[0], 1'b1);
    check("word_ld_mem_addr", 32'(mem_addr[0]), 32'h80);
    wait_done(0, 1'b1, 6, "word_ld");

    // Reset asserted during RMW_WR of a byte store (MEM_LAT=3).
    next_cycle();
    d_req[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 32'h106; d_wdata[1] = 32'h5A;
    d_byte_n[1] = BYTE_N_B;
    repeat (5) @(posedge clk);
    #1;
    rst[1] = 1'b1;
    d_req[1] = 1'b0;
    @(negedge clk);
    check_bit("rst_rmw_mem_we", mem_we[1], 1'b0);
    check_bit("rst_rmw_mem_en", mem_en[1], 1'b0);
    next_cycle();
    rst[1] = 1'b0;
    @(negedge clk);
    check_zero(1, "rst_rmw_after");
    check("rst_rmw_mem_unchanged", g_lat[1].mem[8'h41], 32'h11AB_3344);
    next_cycle();
    issue_data(1, 1'b0, 32'h104, 32'h0, BYTE_N_W, 32'h11AB_3344, 1'b1, 32'h0);
    wait_done(1, 1'b1, 10, "post_rst_load");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
